// File: rtl/boot_pkg.sv
// boot_pkg: state encoding and default parameters shared by the boot controller files
package boot_pkg;
    localparam logic [2:0] ST_LOAD    = 3'd0;
    localparam logic [2:0] ST_CHECK   = 3'd1;
    localparam logic [2:0] ST_FAIL    = 3'd2;
    localparam logic [2:0] ST_RELEASE = 3'd3;
    localparam logic [2:0] ST_RUN     = 3'd4;
    localparam logic [31:0] DEF_END_WORD = 32'hFFFF_FFFF;
    localparam int DEF_IDLE_TIMEOUT = 1000000;
    localparam int DEF_RELEASE_CYCLES = 4;
endpackage

// File: rtl/boot_controller_if.sv
// boot_controller_if: word receiver, instruction-memory write port and CPU control bundle
interface boot_controller_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
);
    logic              word_valid;
    logic [DATA_W-1:0] word_data;
    logic              boot_req;
    logic              imem_wen;
    logic [ADDR_W-1:0] imem_waddr;
    logic [DATA_W-1:0] imem_wdata;
    logic              cpu_reset;
    logic              loading;
    logic [ADDR_W:0]   word_count;
    logic              overflow;
    logic              checksum_err;
    modport master (
        output word_valid, word_data, boot_req,
        input  imem_wen, imem_waddr, imem_wdata, cpu_reset, loading, word_count, overflow, checksum_err
    );
    modport slave (
        input  word_valid, word_data, boot_req,
        output imem_wen, imem_waddr, imem_wdata, cpu_reset, loading, word_count, overflow, checksum_err
    );
endinterface

// File: rtl/boot_timeout.sv
// boot_timeout: idle counter that flags expiry on the enabled cycle that reaches LIMIT
module boot_timeout
    import boot_pkg::*;
#(
    parameter int LIMIT = DEF_IDLE_TIMEOUT
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic en,
    output logic expired
);
    localparam int W = $clog2(LIMIT + 1);
    logic [W-1:0] cnt;
    assign expired = en && cnt == W'(LIMIT - 1);
    // count enabled idle cycles; clear or reset returns to zero
    always_ff @(posedge clock) begin
        if (!reset || clear) cnt <= '0;
        else if (en) cnt <= cnt + W'(1);
    end
endmodule

// File: rtl/boot_controller.sv
// boot_controller: loads received words into instruction memory while holding the CPU in reset.
// Optional BOOT_CHECKSUM_EN: a trailing checksum word is verified after END_WORD (CHECK/FAIL states).
module boot_controller
    import boot_pkg::*;
#(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32,
    parameter logic [DATA_W-1:0] END_WORD = DATA_W'(DEF_END_WORD),
    parameter int IDLE_TIMEOUT = DEF_IDLE_TIMEOUT,
    parameter int RELEASE_CYCLES = DEF_RELEASE_CYCLES
) (
    input logic clock,
    input logic reset,
    boot_controller_if.slave bus
);
    localparam int RW = $clog2(RELEASE_CYCLES + 1);
`ifdef BOOT_CHECKSUM_EN
    localparam logic [2:0] ST_END = ST_CHECK;
`else
    localparam logic [2:0] ST_END = ST_RELEASE;
`endif
    logic [2:0]        state;
    logic [RW-1:0]     rel_cnt;
    logic [ADDR_W:0]   cnt;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;
    logic wv_q, br_q, w_edge, b_edge, loading, expired, wr, wen, ovf;
    assign w_edge = bus.word_valid && !wv_q;
    assign b_edge = bus.boot_req && !br_q;
    assign loading = state == ST_LOAD || state == ST_CHECK;
    assign wr = state == ST_LOAD && w_edge && bus.word_data != END_WORD;
    assign bus.imem_wen = wen;
    assign bus.imem_waddr = waddr;
    assign bus.imem_wdata = wdata;
    assign bus.cpu_reset = state != ST_RUN;
    assign bus.loading = loading;
    assign bus.word_count = cnt;
    assign bus.overflow = ovf;
    boot_timeout #(.LIMIT(IDLE_TIMEOUT)) u_timeout (
        .clock(clock),
        .reset(reset),
        .clear(!loading || w_edge),
        .en(loading && !w_edge),
        .expired(expired)
    );
`ifdef BOOT_CHECKSUM_EN
    logic [DATA_W-1:0] sum;
    logic err;
    // running sum of written words; the error flag latches a wrong or missing checksum word
    always_ff @(posedge clock) begin
        if (!reset || (b_edge && (state == ST_RUN || state == ST_FAIL))) begin
            sum <= '0;
            err <= 1'b0;
        end else begin
            if (wr) sum <= sum + bus.word_data;
            if (state == ST_CHECK && (w_edge ? bus.word_data != sum : expired)) err <= 1'b1;
        end
    end
    assign bus.checksum_err = err;
`else
    assign bus.checksum_err = 1'b0;
`endif
    // edge history, memory write port, word/release counters and state sequencing
    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= ST_LOAD;
            cnt <= '0;
            rel_cnt <= '0;
            wv_q <= 1'b0;
            br_q <= 1'b0;
            wen <= 1'b0;
            waddr <= '0;
            wdata <= '0;
            ovf <= 1'b0;
        end else begin
            wv_q <= bus.word_valid;
            br_q <= bus.boot_req;
            wen <= wr;
            rel_cnt <= state == ST_RELEASE ? rel_cnt + RW'(1) : '0;
            if (w_edge && !loading) ovf <= 1'b1;
            if (wr) begin
                waddr <= cnt[ADDR_W-1:0];
                wdata <= bus.word_data;
                cnt <= cnt + 1'b1;
            end
            case (state)
                ST_LOAD:
                    if (w_edge) state <= !wr ? ST_END : &cnt[ADDR_W-1:0] ? ST_RELEASE : ST_LOAD;
                    else if (expired) state <= ST_RELEASE;
`ifdef BOOT_CHECKSUM_EN
                ST_CHECK:
                    if (w_edge) state <= bus.word_data == sum ? ST_RELEASE : ST_FAIL;
                    else if (expired) state <= ST_FAIL;
`endif
                ST_RELEASE:
                    if (rel_cnt == RW'(RELEASE_CYCLES - 1)) state <= ST_RUN;
                ST_RUN, ST_FAIL:
                    if (b_edge) begin
                        state <= ST_LOAD;
                        cnt <= '0;
                        ovf <= 1'b0;
                    end
                default: state <= ST_LOAD;
            endcase
        end
    end
endmodule

// File: tb/tb_boot_controller.sv
// tb_boot_controller: directed stimulus checked every cycle against a behavioural boot model
module tb_boot_controller;
    localparam int AW = 3;
    localparam int DW = 32;
    localparam int IDLE = 20;
    localparam int REL = 4;
    localparam int DEPTH = 1 << AW;
    localparam logic [31:0] ENDW = 32'hFFFF_FFFF;
`ifdef BOOT_CHECKSUM_EN
    localparam bit CK = 1'b1;
`else
    localparam bit CK = 1'b0;
`endif
    typedef struct {int a; logic [31:0] d; int c;} wr_t;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int cyc = 0, checks = 0, failures = 0, last_edge = 0, rst_cyc = 0;
    wr_t log_q[$];
    bit armed = 0, pv, pb, m_load, m_chk, m_fail, m_run, m_ovf, m_err, m_wen;
    int m_rel, m_idle, m_cnt, m_addr;
    logic [31:0] m_data, m_sum;

    boot_controller_if #(.ADDR_W(AW), .DATA_W(DW)) bus();
    boot_controller #(
        .ADDR_W(AW), .DATA_W(DW), .END_WORD(ENDW), .IDLE_TIMEOUT(IDLE), .RELEASE_CYCLES(REL)
    ) dut (
        .clock(clk),
        .reset(rst_n),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // behavioural model: what the outputs must be after each clock edge
    always @(posedge clk) begin
        bit we, be;
        we = bus.word_valid && !pv;
        be = bus.boot_req && !pb;
        pv = bus.word_valid;
        pb = bus.boot_req;
        m_wen = 0;
        if (!rst_n) begin
            armed = 1; pv = 0; pb = 0;
            m_load = 1; m_chk = 0; m_fail = 0; m_run = 0; m_rel = 0; m_idle = 0;
            m_cnt = 0; m_ovf = 0; m_err = 0; m_addr = 0; m_data = 0; m_sum = 0;
        end else begin
            if (we && !(m_load || m_chk)) m_ovf = 1;
            if (m_load) begin
                if (we) begin
                    m_idle = 0;
                    if (bus.word_data == ENDW) begin
                        m_load = 0;
                        if (CK) m_chk = 1; else m_rel = REL;
                    end else begin
                        m_wen = 1; m_addr = m_cnt; m_data = bus.word_data;
                        m_sum = m_sum + bus.word_data;
                        m_cnt++;
                        if (m_cnt == DEPTH) begin m_load = 0; m_rel = REL; end
                    end
                end else if (++m_idle == IDLE) begin
                    m_load = 0; m_rel = REL;
                end
            end else if (m_chk) begin
                if (we) begin
                    m_chk = 0;
                    if (bus.word_data == m_sum) m_rel = REL; else begin m_fail = 1; m_err = 1; end
                end else if (++m_idle == IDLE) begin
                    m_chk = 0; m_fail = 1; m_err = 1;
                end
            end else if (m_rel > 0) begin
                m_rel--;
                if (m_rel == 0) m_run = 1;
            end else if ((m_run || m_fail) && be) begin
                m_run = 0; m_fail = 0; m_load = 1; m_cnt = 0; m_ovf = 0; m_err = 0; m_sum = 0; m_idle = 0;
            end
        end
    end

    // per-cycle comparison against the model
    always @(negedge clk) if (armed) begin
        chk("imem_wen", 64'(bus.imem_wen), 64'(m_wen));
        chk("cpu_reset", 64'(bus.cpu_reset), 64'(!m_run));
        chk("loading", 64'(bus.loading), 64'(m_load || m_chk));
        chk("word_count", 64'(bus.word_count), 64'(m_cnt));
        chk("overflow", 64'(bus.overflow), 64'(m_ovf));
        chk("checksum_err", 64'(bus.checksum_err), 64'(m_err));
        if (m_wen) begin
            chk("imem_waddr", 64'(bus.imem_waddr), 64'(m_addr));
            chk("imem_wdata", 64'(bus.imem_wdata), 64'(m_data));
        end
    end

    always @(negedge clk) if (bus.imem_wen === 1'b1) log_q.push_back('{int'(bus.imem_waddr), bus.imem_wdata, cyc});

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        log_q.delete();
        rst_cyc = cyc;
    endtask

    task automatic send(input logic [31:0] w);
        bus.word_valid = 1'b1;
        bus.word_data = w;
        last_edge = cyc;
        tick();
        bus.word_valid = 1'b0;
        repeat (2) tick();
    endtask

    task automatic pulse_boot();
        bus.boot_req = 1'b1;
        tick();
        bus.boot_req = 1'b0;
        repeat (2) tick();
    endtask

    task automatic wait_run();
        for (int i = 0; i < 200 && bus.cpu_reset !== 1'b0; i++) tick();
        chk("cpu_release_seen", 64'(bus.cpu_reset), 64'(0));
    endtask

    initial begin
        int e[3];
        int ee;
        logic [31:0] s1d[3];
        s1d = '{32'h11, 32'h22, 32'h33};
        bus.word_valid = 1'b0;
        bus.word_data = '0;
        bus.boot_req = 1'b0;

        do_reset();
        chk("rst_cpu_reset", 64'(bus.cpu_reset), 64'(1));
        chk("rst_loading", 64'(bus.loading), 64'(1));
        chk("rst_word_count", 64'(bus.word_count), 64'(0));
        chk("rst_waddr", 64'(bus.imem_waddr), 64'(0));
        chk("rst_wdata", 64'(bus.imem_wdata), 64'(0));
        chk("rst_wen", 64'(bus.imem_wen), 64'(0));
        for (int i = 0; i < 3; i++) begin send(s1d[i]); e[i] = last_edge; end
        send(ENDW);
        ee = last_edge;
        chk("s1_count", 64'(bus.word_count), 64'(3));
        wait_run();
        chk("s1_release_delay", 64'(cyc - (ee + 1)), 64'(4));
        chk("s1_nwrites", 64'(log_q.size()), 64'(3));
        for (int i = 0; i < 3 && i < log_q.size(); i++) begin
            chk("s1_addr", 64'(log_q[i].a), 64'(i));
            chk("s1_data", 64'(log_q[i].d), 64'(s1d[i]));
            chk("s1_latency", 64'(log_q[i].c - e[i]), 64'(1));
        end

        send(32'h55);
        chk("run_overflow", 64'(bus.overflow), 64'(1));
        chk("run_no_write", 64'(log_q.size()), 64'(3));
        pulse_boot();
        chk("boot_ovf_clear", 64'(bus.overflow), 64'(0));
        chk("boot_cpu_reset", 64'(bus.cpu_reset), 64'(1));
        chk("boot_count", 64'(bus.word_count), 64'(0));
        send(32'h66);
        chk("boot_nwrites", 64'(log_q.size()), 64'(4));
        if (log_q.size() == 4) begin
            chk("boot_addr", 64'(log_q[3].a), 64'(0));
            chk("boot_data", 64'(log_q[3].d), 64'(32'h66));
        end

        do_reset();
        wait_run();
        chk("timeout_hold", 64'(cyc - rst_cyc), 64'(IDLE + REL));
        chk("timeout_no_write", 64'(log_q.size()), 64'(0));

        do_reset();
        repeat (IDLE - 1) tick();
        send(32'h77);
        chk("word_beats_timeout", 64'(bus.loading), 64'(1));
        chk("wbt_nwrites", 64'(log_q.size()), 64'(1));

        do_reset();
        for (int i = 0; i < 9; i++) send(32'hA0 + 32'(i));
        chk("full_nwrites", 64'(log_q.size()), 64'(8));
        for (int i = 0; i < 8 && i < log_q.size(); i++) begin
            chk("full_addr", 64'(log_q[i].a), 64'(i));
            chk("full_data", 64'(log_q[i].d), 64'(32'hA0 + i));
        end
        chk("full_count", 64'(bus.word_count), 64'(8));
        chk("full_overflow", 64'(bus.overflow), 64'(1));

        do_reset();
        send(32'h10);
        send(32'h20);
        bus.word_valid = 1'b1;
        bus.word_data = 32'h30;
        rst_n = 1'b0;
        tick();
        bus.word_valid = 1'b0;
        rst_n = 1'b1;
        repeat (2) tick();
        chk("midrst_nwrites", 64'(log_q.size()), 64'(2));
        chk("midrst_count", 64'(bus.word_count), 64'(0));
        send(32'h40);
        chk("midrst_nwrites2", 64'(log_q.size()), 64'(3));
        if (log_q.size() == 3) begin
            chk("midrst_addr", 64'(log_q[2].a), 64'(0));
            chk("midrst_data", 64'(log_q[2].d), 64'(32'h40));
        end

`ifdef BOOT_CHECKSUM_EN
        do_reset();
        send(32'd1);
        send(32'd2);
        send(ENDW);
        send(32'd3);
        wait_run();
        chk("ck_ok_err", 64'(bus.checksum_err), 64'(0));
        do_reset();
        send(32'd1);
        send(32'd2);
        send(ENDW);
        send(32'd4);
        chk("ck_bad_err", 64'(bus.checksum_err), 64'(1));
        repeat (30) tick();
        chk("ck_bad_hold", 64'(bus.cpu_reset), 64'(1));
        pulse_boot();
        chk("ck_boot_err", 64'(bus.checksum_err), 64'(0));
        chk("ck_boot_loading", 64'(bus.loading), 64'(1));
`endif

        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
